// File: rtl/iccm_frame_loader.sv
// UART boot loader: parses A5/N/BASE/data/CK frames into ICCM word writes.
// Ports: clk_i/rst_ni, rx_dv_i/rx_byte_i in; we_o/addr_o/wdata_o ICCM, hold_rst_o/busy_o/done_o/err_o status.
module iccm_frame_loader #(
  parameter int unsigned AddrW         = 12,
  parameter int unsigned DataW         = 32,
  parameter logic [7:0]  Magic         = 8'hA5,
  parameter int unsigned TimeoutCycles = 1000000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rx_dv_i,
  input  logic [7:0]       rx_byte_i,
  output logic             we_o,
  output logic [AddrW-1:0] addr_o,
  output logic [DataW-1:0] wdata_o,
  output logic             hold_rst_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       err_o
);

  localparam int unsigned TW = $clog2(TimeoutCycles + 1);
  localparam logic [TW-1:0] TLast = TW'(TimeoutCycles - 1);
  localparam logic [16:0] Depth = 17'(2 ** AddrW);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_e;

  state_e state_q, state_d;
  logic [1:0] err_q, err_d;

  logic [1:0]       hcnt_q;
  logic [15:0]      n_q;
  logic [7:0]       base_lo_q;
  logic [AddrW-1:0] base_q;
  logic [7:0]       sum_q;
  logic [1:0]       bcnt_q;
  logic [DataW-9:0] asm_q;
  logic [16:0]      widx_q;
  logic [TW-1:0]    tcnt_q;
  logic             we_q;
  logic [AddrW-1:0] addr_q;
  logic [DataW-1:0] wdata_q;

  logic        is_magic, start, active;
  logic        hdr_last, hdr_bad, words_done;
  logic        tmo, ck_ok;
  logic [7:0]  sum_nxt;
  logic [15:0] base_full;

  assign is_magic   = rx_dv_i && (rx_byte_i == Magic);
  assign start      = is_magic && (state_q == S_IDLE ||
                                   state_q == S_DONE ||
                                   state_q == S_ERR);
  assign active     = (state_q == S_HDR) || (state_q == S_DATA) ||
                      (state_q == S_CSUM);
  assign sum_nxt    = sum_q + rx_byte_i;
  assign ck_ok      = (sum_nxt == 8'h00);
  assign hdr_last   = rx_dv_i && (hcnt_q == 2'd3);
  assign base_full  = {rx_byte_i, base_lo_q};
  assign hdr_bad    = ({1'b0, n_q} > Depth) ||
                      ((base_full >> AddrW) != 16'd0);
  // True only in the cycle the final write pulse is out; a byte then is CK.
  assign words_done = (widx_q == {1'b0, n_q});
  assign tmo        = !rx_dv_i && (tcnt_q == TLast);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      err_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (is_magic) begin
          state_d = S_HDR;
          err_d   = 2'd0;
        end
      end
      S_HDR: begin
        if (tmo) begin
          state_d = S_ERR;
          err_d   = 2'd3;
        end else if (hdr_last) begin
          if (hdr_bad) begin
            state_d = S_ERR;
            err_d   = 2'd1;
          end else if (n_q == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (words_done) begin
          if (rx_dv_i) begin
            state_d = ck_ok ? S_DONE : S_ERR;
            err_d   = ck_ok ? 2'd0 : 2'd2;
          end else begin
            state_d = S_CSUM;
          end
        end else if (tmo) begin
          state_d = S_ERR;
          err_d   = 2'd3;
        end
      end
      S_CSUM: begin
        if (tmo) begin
          state_d = S_ERR;
          err_d   = 2'd3;
        end else if (rx_dv_i) begin
          state_d = ck_ok ? S_DONE : S_ERR;
          err_d   = ck_ok ? 2'd0 : 2'd2;
        end
      end
      S_DONE: begin
        state_d = is_magic ? S_HDR : S_IDLE;
      end
      S_ERR: begin
        if (is_magic) begin
          state_d = S_HDR;
          err_d   = 2'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hcnt_q    <= '0;
      n_q       <= '0;
      base_lo_q <= '0;
      base_q    <= '0;
      sum_q     <= '0;
      bcnt_q    <= '0;
      asm_q     <= '0;
      widx_q    <= '0;
      tcnt_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      we_q <= 1'b0;
      if (start) begin
        hcnt_q <= '0;
        sum_q  <= '0;
        bcnt_q <= '0;
        widx_q <= '0;
        tcnt_q <= '0;
      end else if (active) begin
        tcnt_q <= rx_dv_i ? '0 : tcnt_q + 1'b1;
        if (rx_dv_i) sum_q <= sum_nxt;
      end
      if (state_q == S_HDR && rx_dv_i) begin
        hcnt_q <= hcnt_q + 2'd1;
        unique case (hcnt_q)
          2'd0: n_q[7:0]  <= rx_byte_i;
          2'd1: n_q[15:8] <= rx_byte_i;
          2'd2: base_lo_q <= rx_byte_i;
          default: base_q <= base_full[AddrW-1:0];
        endcase
      end
      if (state_q == S_DATA && rx_dv_i && !words_done) begin
        bcnt_q <= bcnt_q + 2'd1;
        asm_q  <= {rx_byte_i, asm_q[DataW-9:8]};
        if (bcnt_q == 2'd3) begin
          we_q    <= 1'b1;
          addr_q  <= base_q + widx_q[AddrW-1:0];
          wdata_q <= {rx_byte_i, asm_q};
          widx_q  <= widx_q + 17'd1;
        end
      end
    end
  end

  always_comb begin
    we_o       = we_q;
    addr_o     = addr_q;
    wdata_o    = wdata_q;
    err_o      = err_q;
    busy_o     = active;
    hold_rst_o = active || (state_q == S_ERR);
    done_o     = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_iccm_frame_loader.sv
// Directed bench for iccm_frame_loader.
// Frames are built from word tables; writes and done pulses are logged.
module tb_iccm_frame_loader;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        rx_dv_i;
  logic [7:0]  rx_byte_i;
  logic        we_o;
  logic [11:0] addr_o;
  logic [31:0] wdata_o;
  logic        hold_rst_o;
  logic        busy_o;
  logic        done_o;
  logic [1:0]  err_o;

  iccm_frame_loader #(
    .AddrW(12),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .rx_dv_i(rx_dv_i),
    .rx_byte_i(rx_byte_i),
    .we_o(we_o),
    .addr_o(addr_o),
    .wdata_o(wdata_o),
    .hold_rst_o(hold_rst_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];
  logic [7:0]  fb[$];
  logic [31:0] wd[8];
  logic [7:0]  fsum;

  always @(negedge clk) begin
    if (we_o) begin
      wr_a.push_back({20'd0, addr_o});
      wr_d.push_back(wdata_o);
    end
    if (done_o) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic check_wr(input string tag, input int i,
                          input logic [31:0] a, input logic [31:0] d);
    n_tests++;
    if (i >= wr_a.size()) begin
      n_fail++;
      $display("FAIL %s: write %0d missing, expected %h@%h", tag, i, d, a);
    end else if (wr_a[i] !== a || wr_d[i] !== d) begin
      n_fail++;
      $display("FAIL %s: got %h@%h, expected %h@%h",
               tag, wr_d[i], wr_a[i], d, a);
    end
  endtask

  task automatic clear_mon();
    wr_a.delete();
    wr_d.delete();
    done_cnt = 0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dv_i   = 1'b1;
    rx_byte_i = b;
    @(negedge clk);
    rx_dv_i   = 1'b0;
  endtask

  task automatic put(input logic [7:0] b);
    fb.push_back(b);
    fsum = fsum + b;
  endtask

  task automatic build(input logic [15:0] n, input logic [15:0] base,
                       input logic [7:0] ck_add);
    fb.delete();
    fb.push_back(8'hA5);
    fsum = 8'h00;
    put(n[7:0]);
    put(n[15:8]);
    put(base[7:0]);
    put(base[15:8]);
    for (int i = 0; i < int'(n) && i < 8; i++)
      for (int b = 0; b < 4; b++) put(wd[i][8*b +: 8]);
    fb.push_back(8'(8'h00 - fsum) + ck_add);
  endtask

  task automatic send_range(input int from, input int to, input int gap);
    for (int i = from; i < to; i++) begin
      send_byte(fb[i]);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic check_ok(input string tag, input int nwr);
    check({tag, "_nwr"}, wr_a.size(), nwr);
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_hold"}, {31'd0, hold_rst_o}, 0);
    check({tag, "_err"}, {30'd0, err_o}, 0);
    check({tag, "_busy"}, {31'd0, busy_o}, 0);
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_we"}, {31'd0, we_o}, 0);
    check({tag, "_addr"}, {20'd0, addr_o}, 0);
    check({tag, "_wdata"}, wdata_o, 0);
    check({tag, "_flags"}, {28'd0, hold_rst_o, busy_o, done_o, 1'b0}, 0);
    check({tag, "_err"}, {30'd0, err_o}, 0);
  endtask

  initial begin
    rst_ni    = 1'b0;
    rx_dv_i   = 1'b0;
    rx_byte_i = 8'h00;
    idle(3);
    check_rst("reset");
    rst_ni = 1'b1;
    idle(2);

    // Garbage before magic, then valid frame with spaced bytes.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    idle(1);
    check("garbage_busy", {31'd0, busy_o}, 0);
    check("garbage_hold", {31'd0, hold_rst_o}, 0);
    wd[0] = 32'h44332211;
    wd[1] = 32'hDDCCBBAA;
    build(16'd2, 16'h0010, 8'h00);
    clear_mon();
    send_range(0, 1, 0);
    check("a_hold_after_magic", {31'd0, hold_rst_o}, 1);
    check("a_busy_after_magic", {31'd0, busy_o}, 1);
    send_range(1, fb.size(), 1);
    idle(3);
    check_ok("a", 2);
    check_wr("a_w0", 0, 32'h010, 32'h44332211);
    check_wr("a_w1", 1, 32'h011, 32'hDDCCBBAA);

    // Bad checksum: words land, error 2, core stays held.
    build(16'd2, 16'h0010, 8'h01);
    clear_mon();
    send_range(0, fb.size(), 0);
    idle(3);
    check("ck_nwr", wr_a.size(), 2);
    check("ck_err", {30'd0, err_o}, 2);
    check("ck_hold", {31'd0, hold_rst_o}, 1);
    check("ck_done", done_cnt, 0);
    check("ck_busy", {31'd0, busy_o}, 0);

    // Recovery frame from ERR.
    wd[0] = 32'hCAFEF00D;
    build(16'd1, 16'h0020, 8'h00);
    clear_mon();
    send_range(0, 1, 0);
    check("rec_err_clr", {30'd0, err_o}, 0);
    send_range(1, fb.size(), 0);
    idle(3);
    check_ok("rec", 1);
    check_wr("rec_w0", 0, 32'h020, 32'hCAFEF00D);

    // Out-of-range base.
    build(16'd1, 16'h1000, 8'h00);
    clear_mon();
    send_range(0, 5, 0);
    check("bbase_err", {30'd0, err_o}, 1);
    check("bbase_hold", {31'd0, hold_rst_o}, 1);
    idle(2);
    check("bbase_nwr", wr_a.size(), 0);

    // Oversized word count.
    build(16'h1001, 16'h0000, 8'h00);
    send_range(0, 5, 0);
    check("bn_err", {30'd0, err_o}, 1);
    idle(2);
    check("bn_nwr", wr_a.size(), 0);

    // Empty frame.
    build(16'd0, 16'h0000, 8'h00);
    clear_mon();
    send_range(0, fb.size(), 0);
    idle(2);
    check_ok("empty", 0);

    // Address wrap at top of ICCM.
    wd[0] = 32'h01020304;
    wd[1] = 32'h05060708;
    build(16'd2, 16'h0FFF, 8'h00);
    clear_mon();
    send_range(0, fb.size(), 0);
    idle(3);
    check_ok("wrap", 2);
    check_wr("wrap_w0", 0, 32'hFFF, 32'h01020304);
    check_wr("wrap_w1", 1, 32'h000, 32'h05060708);

    // Stall of TO cycles after 3 data bytes times out.
    wd[0] = 32'h0A0B0C0D;
    build(16'd1, 16'h0005, 8'h00);
    clear_mon();
    send_range(0, 8, 0);
    idle(TO - 1);
    check("tmo_err_early", {30'd0, err_o}, 0);
    idle(1);
    check("tmo_err", {30'd0, err_o}, 3);
    check("tmo_hold", {31'd0, hold_rst_o}, 1);
    idle(2);
    check("tmo_nwr", wr_a.size(), 0);

    // Stall of TO-1 cycles then resume.
    build(16'd1, 16'h0006, 8'h00);
    clear_mon();
    send_range(0, 8, 0);
    idle(TO - 1);
    send_range(8, fb.size(), 0);
    idle(3);
    check_ok("stall", 1);
    check_wr("stall_w0", 0, 32'h006, 32'h0A0B0C0D);

    // Reset in the middle of DATA.
    wd[0] = 32'h11111111;
    wd[1] = 32'h22222222;
    build(16'd2, 16'h0030, 8'h00);
    send_range(0, 10, 0);
    rst_ni = 1'b0;
    idle(1);
    check_rst("midrst");
    rst_ni = 1'b1;
    clear_mon();
    idle(5);
    check("midrst_nwr", wr_a.size(), 0);
    wd[0] = 32'h55AA55AA;
    build(16'd1, 16'h0031, 8'h00);
    send_range(0, fb.size(), 0);
    idle(3);
    check_ok("post_rst", 1);
    check_wr("post_rst_w0", 0, 32'h031, 32'h55AA55AA);

    // Four words with rx_dv_i held high; includes a magic value as data.
    wd[0] = 32'hA5A5A5A5;
    wd[1] = 32'h87654321;
    wd[2] = 32'h00000000;
    wd[3] = 32'hFFFFFFFF;
    build(16'd4, 16'h0100, 8'h00);
    clear_mon();
    send_range(0, fb.size(), 0);
    idle(3);
    check_ok("b2b", 4);
    for (int i = 0; i < 4; i++)
      check_wr($sformatf("b2b_w%0d", i), i, 32'h100 + i, wd[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
